// File: rtl/gps_ack_peak.sv
// Per-lane acquisition peak tracker with sweep-end result FIFO (registered FWFT output).
// Optional macro GPS_ACK_SECOND_PEAK_EN adds second-peak tracking and the res_second port.
module gps_ack_peak #(
    parameter int INT_W      = 12,
    parameter int HALF       = 2048,
    parameter int FIFO_DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ack_start,
    input  logic             corr_complete,
    input  logic [9:0]       code_phase,
    input  logic [5:0]       sat0,
    input  logic [5:0]       sat1,
    input  logic [5:0]       sat2,
    input  logic [5:0]       sat3,
    input  logic [INT_W-1:0] integrator_0,
    input  logic [INT_W-1:0] integrator_1,
    input  logic [INT_W-1:0] integrator_2,
    input  logic [INT_W-1:0] integrator_3,
    input  logic [11:0]      threshold,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [5:0]       res_sat,
    output logic [9:0]       res_phase,
    output logic [11:0]      res_peak,
    output logic             res_detect,
`ifdef GPS_ACK_SECOND_PEAK_EN
    output logic [11:0]      res_second,
`endif
    output logic             overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic signed [INT_W:0] HALF_S = (INT_W+1)'(HALF);

    typedef struct packed {
        logic [5:0]  sat;
        logic [9:0]  phase;
        logic [11:0] peak;
        logic        detect;
`ifdef GPS_ACK_SECOND_PEAK_EN
        logic [11:0] second;
`endif
    } rec_t;

    typedef enum logic [2:0] {S_IDLE, S_PUSH0, S_PUSH1, S_PUSH2, S_PUSH3} state_t;

    function automatic logic [11:0] mag_of(input logic [INT_W-1:0] v);
        logic signed [INT_W:0] d;
        logic        [INT_W:0] a;
        d = $signed({1'b0, v}) - HALF_S;
        a = d[INT_W] ? $unsigned(-d) : $unsigned(d);
        return 12'(a);
    endfunction

`ifdef GPS_ACK_SECOND_PEAK_EN
    function automatic logic adjacent(input logic [9:0] a, input logic [9:0] b);
        logic [9:0] d;
        d = a - b;
        return (d == 10'd0) || (d == 10'd1) || (d == 10'd1023);
    endfunction
`endif

    // Stage 0: rising-edge capture of corr_complete
    logic             cc_prev;
    logic             capture;
    logic [INT_W-1:0] integ_p0 [4];
    logic [5:0]       sat_p0 [4];

    assign capture = corr_complete & ~cc_prev;

    always_comb begin
        integ_p0[0] = integrator_0;
        integ_p0[1] = integrator_1;
        integ_p0[2] = integrator_2;
        integ_p0[3] = integrator_3;
        sat_p0[0]   = sat0;
        sat_p0[1]   = sat1;
        sat_p0[2]   = sat2;
        sat_p0[3]   = sat3;
    end

    // Stage 1: magnitudes and result phase
    logic        vld_p1;
    logic [9:0]  phase_p1;
    logic [11:0] mag_p1 [4];
    logic [5:0]  sat_p1 [4];

    always_ff @(posedge clk) begin
        if (rst) cc_prev <= 1'b0;
        else     cc_prev <= corr_complete;
        if (rst || ack_start) vld_p1 <= 1'b0;
        else                  vld_p1 <= capture;
        if (capture) begin
            phase_p1 <= code_phase - 10'd1;
            for (int i = 0; i < 4; i++) begin
                mag_p1[i] <= mag_of(integ_p0[i]);
                sat_p1[i] <= sat_p0[i];
            end
        end
    end

    // Stage 2: peak trackers
    logic [11:0] peak_p2 [4];
    logic [11:0] peak_nxt [4];
    logic [9:0]  pphase_p2 [4];
    logic [9:0]  pphase_nxt [4];
    logic        det_nxt [4];
`ifdef GPS_ACK_SECOND_PEAK_EN
    logic [11:0] second_p2 [4];
    logic [11:0] second_nxt [4];
`endif

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            peak_nxt[i]   = peak_p2[i];
            pphase_nxt[i] = pphase_p2[i];
`ifdef GPS_ACK_SECOND_PEAK_EN
            second_nxt[i] = second_p2[i];
`endif
            if (phase_p1 == 10'd0) begin
                peak_nxt[i]   = mag_p1[i];
                pphase_nxt[i] = 10'd0;
`ifdef GPS_ACK_SECOND_PEAK_EN
                second_nxt[i] = 12'd0;
`endif
            end else if (mag_p1[i] > peak_p2[i]) begin
                peak_nxt[i]   = mag_p1[i];
                pphase_nxt[i] = phase_p1;
`ifdef GPS_ACK_SECOND_PEAK_EN
                if (!adjacent(phase_p1, pphase_p2[i])) second_nxt[i] = peak_p2[i];
`endif
            end
`ifdef GPS_ACK_SECOND_PEAK_EN
            else if (!adjacent(phase_p1, pphase_p2[i]) && (mag_p1[i] > second_p2[i])) begin
                second_nxt[i] = mag_p1[i];
            end
            det_nxt[i] = (peak_nxt[i] >= threshold) &&
                         ({1'b0, peak_nxt[i]} >= ({1'b0, second_nxt[i]} + {2'b00, second_nxt[i][11:1]}));
`else
            det_nxt[i] = (peak_nxt[i] >= threshold);
`endif
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (rst || ack_start) begin
                peak_p2[i]   <= 12'd0;
                pphase_p2[i] <= 10'd0;
`ifdef GPS_ACK_SECOND_PEAK_EN
                second_p2[i] <= 12'd0;
`endif
            end else if (vld_p1) begin
                peak_p2[i]   <= peak_nxt[i];
                pphase_p2[i] <= pphase_nxt[i];
`ifdef GPS_ACK_SECOND_PEAK_EN
                second_p2[i] <= second_nxt[i];
`endif
            end
        end
    end

    // Sweep-end sequencer: latch the final records, then push lanes 0..3
    state_t      state, state_nxt;
    logic        sweep_end;
    logic        push;
    logic [1:0]  push_lane;
    rec_t        seq_rec [4];

    assign sweep_end = vld_p1 && (phase_p1 == 10'd1023) && (state == S_IDLE);

    always_ff @(posedge clk) begin
        if (rst || ack_start) state <= S_IDLE;
        else                  state <= state_nxt;
        if (sweep_end) begin
            for (int i = 0; i < 4; i++) begin
                seq_rec[i].sat    <= sat_p1[i];
                seq_rec[i].phase  <= pphase_nxt[i];
                seq_rec[i].peak   <= peak_nxt[i];
                seq_rec[i].detect <= det_nxt[i];
`ifdef GPS_ACK_SECOND_PEAK_EN
                seq_rec[i].second <= second_nxt[i];
`endif
            end
        end
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        push_lane = 2'd0;
        unique case (state)
            S_IDLE:  if (sweep_end) state_nxt = S_PUSH0;
            S_PUSH0: begin push = 1'b1; push_lane = 2'd0; state_nxt = S_PUSH1; end
            S_PUSH1: begin push = 1'b1; push_lane = 2'd1; state_nxt = S_PUSH2; end
            S_PUSH2: begin push = 1'b1; push_lane = 2'd2; state_nxt = S_PUSH3; end
            S_PUSH3: begin push = 1'b1; push_lane = 2'd3; state_nxt = S_IDLE;  end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Result FIFO; the output register trails the memory by one cycle
    rec_t          mem [FIFO_DEPTH];
    rec_t          out_rec;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          pop, full, wr_en, drop;

    assign pop   = res_valid & res_ready;
    assign full  = (count == FULL_CNT);
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= seq_rec[push_lane];
    end

    always_ff @(posedge clk) begin
        if (rst || ack_start) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            res_valid <= 1'b0;
            out_rec   <= '0;
            overflow  <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            count     <= count + (AW+1)'(wr_en) - (AW+1)'(pop);
            res_valid <= (count - (AW+1)'(pop)) != '0;
            out_rec   <= mem[rd_ptr + AW'(pop)];
            if (drop) overflow <= 1'b1;
        end
    end

    assign res_sat    = out_rec.sat;
    assign res_phase  = out_rec.phase;
    assign res_peak   = out_rec.peak;
    assign res_detect = out_rec.detect;
`ifdef GPS_ACK_SECOND_PEAK_EN
    assign res_second = out_rec.second;
`endif

endmodule
